// File: rtl/eth_stack_pkg.sv
// Shared definitions for the Ethernet stack TX path: state encoding,
// grant bit positions and the default stream width.
package eth_stack_pkg;

  localparam int DATA_W_DEF = 64;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND_ARP  = 2'd1;
  localparam logic [1:0] ST_SEND_ICMP = 2'd2;
  localparam logic [1:0] ST_SEND_UDP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    SEND_ARP  = ST_SEND_ARP,
    SEND_ICMP = ST_SEND_ICMP,
    SEND_UDP  = ST_SEND_UDP
  } arb_state_e;

  localparam int GNT_ARP  = 0;
  localparam int GNT_ICMP = 1;
  localparam int GNT_UDP  = 2;

  function automatic logic [2:0] grant_of(input arb_state_e st);
    logic [2:0] g;
    g = '0;
    case (st)
      SEND_ARP:  g[GNT_ARP]  = 1'b1;
      SEND_ICMP: g[GNT_ICMP] = 1'b1;
      SEND_UDP:  g[GNT_UDP]  = 1'b1;
      default:   g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer. Output and input-side ready are both
// registered, so no combinational path runs from m_tready to s_tready.
module axis_skid_buffer #(
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic [DATA_W/8-1:0]   s_tkeep,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [DATA_W-1:0]     m_tdata,
  output logic [DATA_W/8-1:0]   m_tkeep,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready
);

  localparam int BEAT_W = DATA_W + DATA_W/8 + 1;

  logic [BEAT_W-1:0] skid_q;
  logic              skid_valid;
  logic              in_fire;

  assign in_fire = s_tvalid & s_tready;

  // Output register refills from the skid entry first, then from the input;
  // the skid entry only catches a beat that arrives while the output stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tdata    <= '0;
      m_tkeep    <= '0;
      m_tlast    <= 1'b0;
      m_tvalid   <= 1'b0;
      skid_q     <= '0;
      skid_valid <= 1'b0;
      s_tready   <= 1'b0;
    end else if (!m_tvalid || m_tready) begin
      if (skid_valid) begin
        {m_tdata, m_tkeep, m_tlast} <= skid_q;
        m_tvalid   <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        m_tvalid <= in_fire;
        if (in_fire) begin
          {m_tdata, m_tkeep, m_tlast} <= {s_tdata, s_tkeep, s_tlast};
        end
      end
      s_tready <= 1'b1;
    end else if (in_fire) begin
      skid_q     <= {s_tdata, s_tkeep, s_tlast};
      skid_valid <= 1'b1;
      s_tready   <= 1'b0;
    end else begin
      s_tready <= !skid_valid;
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-level arbiter for the MAC TX stream: ARP > ICMP > UDP, with a
// starvation guard that forces a UDP grant after STARVE_LIMIT consecutive
// higher-priority frames while UDP waits. Grants never change mid-frame.
module eth_tx_arbiter
  import eth_stack_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                tx_axis_aclk,
  input  logic                tx_axis_areset,
  input  logic                udp_enable,
  input  logic [DATA_W-1:0]   arp_tx_axis_tdata,
  input  logic [DATA_W/8-1:0] arp_tx_axis_tkeep,
  input  logic                arp_tx_axis_tvalid,
  input  logic                arp_tx_axis_tlast,
  output logic                arp_tx_axis_tready,
  input  logic [DATA_W-1:0]   icmp_tx_axis_tdata,
  input  logic [DATA_W/8-1:0] icmp_tx_axis_tkeep,
  input  logic                icmp_tx_axis_tvalid,
  input  logic                icmp_tx_axis_tlast,
  output logic                icmp_tx_axis_tready,
  input  logic [DATA_W-1:0]   udp_tx_axis_tdata,
  input  logic [DATA_W/8-1:0] udp_tx_axis_tkeep,
  input  logic                udp_tx_axis_tvalid,
  input  logic                udp_tx_axis_tlast,
  output logic                udp_tx_axis_tready,
  output logic [DATA_W-1:0]   mac_tx_axis_tdata,
  output logic [DATA_W/8-1:0] mac_tx_axis_tkeep,
  output logic                mac_tx_axis_tvalid,
  output logic                mac_tx_axis_tlast,
  input  logic                mac_tx_axis_tready,
  output logic [2:0]          grant,
  output logic [CNT_W-1:0]    arp_frame_cnt,
  output logic [CNT_W-1:0]    icmp_frame_cnt,
  output logic [CNT_W-1:0]    udp_frame_cnt
);

  localparam int KEEP_W   = DATA_W / 8;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q;
  logic                buf_ready;
  logic [DATA_W-1:0]   sel_tdata;
  logic [KEEP_W-1:0]   sel_tkeep;
  logic                sel_tvalid, sel_tlast;
  logic                beat_fire, frame_done, udp_eligible;

  assign udp_eligible = udp_tx_axis_tvalid & udp_enable;
  assign grant        = grant_of(state_q);

  assign arp_tx_axis_tready  = (state_q == SEND_ARP)  & buf_ready;
  assign icmp_tx_axis_tready = (state_q == SEND_ICMP) & buf_ready;
  assign udp_tx_axis_tready  = (state_q == SEND_UDP)  & buf_ready;

  assign beat_fire  = sel_tvalid & buf_ready;
  assign frame_done = beat_fire & sel_tlast;

  // Route the granted source toward the output buffer; nothing while idle.
  always_comb begin
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    case (state_q)
      SEND_ARP: begin
        sel_tdata  = arp_tx_axis_tdata;
        sel_tkeep  = arp_tx_axis_tkeep;
        sel_tvalid = arp_tx_axis_tvalid;
        sel_tlast  = arp_tx_axis_tlast;
      end
      SEND_ICMP: begin
        sel_tdata  = icmp_tx_axis_tdata;
        sel_tkeep  = icmp_tx_axis_tkeep;
        sel_tvalid = icmp_tx_axis_tvalid;
        sel_tlast  = icmp_tx_axis_tlast;
      end
      SEND_UDP: begin
        sel_tdata  = udp_tx_axis_tdata;
        sel_tkeep  = udp_tx_axis_tkeep;
        sel_tvalid = udp_tx_axis_tvalid;
        sel_tlast  = udp_tx_axis_tlast;
      end
      default: ;
    endcase
  end

  // Arbitrate only in IDLE; a granted source keeps the port until its tlast.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if ((starve_q == STARVE_MAX) && udp_eligible) state_d = SEND_UDP;
        else if (arp_tx_axis_tvalid)                  state_d = SEND_ARP;
        else if (icmp_tx_axis_tvalid)                 state_d = SEND_ICMP;
        else if (udp_eligible)                        state_d = SEND_UDP;
      end
      default: if (frame_done) state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
    if (tx_axis_areset) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Per-source frame counters and the UDP starvation counter, both
  // updated when a frame's last beat is accepted.
  always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
    if (tx_axis_areset) begin
      arp_frame_cnt  <= '0;
      icmp_frame_cnt <= '0;
      udp_frame_cnt  <= '0;
      starve_q       <= '0;
    end else if (frame_done) begin
      case (state_q)
        SEND_ARP:  arp_frame_cnt  <= arp_frame_cnt + 1'b1;
        SEND_ICMP: icmp_frame_cnt <= icmp_frame_cnt + 1'b1;
        SEND_UDP:  udp_frame_cnt  <= udp_frame_cnt + 1'b1;
        default: ;
      endcase
      if (state_q == SEND_UDP)          starve_q <= '0;
      else if (!udp_eligible)           starve_q <= '0;
      else if (starve_q != STARVE_MAX)  starve_q <= starve_q + 1'b1;
    end
  end

  axis_skid_buffer #(.DATA_W(DATA_W)) u_skid (
    .clk      (tx_axis_aclk),
    .rst      (tx_axis_areset),
    .s_tdata  (sel_tdata),
    .s_tkeep  (sel_tkeep),
    .s_tvalid (sel_tvalid),
    .s_tlast  (sel_tlast),
    .s_tready (buf_ready),
    .m_tdata  (mac_tx_axis_tdata),
    .m_tkeep  (mac_tx_axis_tkeep),
    .m_tvalid (mac_tx_axis_tvalid),
    .m_tlast  (mac_tx_axis_tlast),
    .m_tready (mac_tx_axis_tready)
  );

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: per-source frame queues drive the three inputs,
// an expected-beat queue built from the arbitration rules checks the MAC side.
module tb_eth_tx_arbiter;

  localparam int LIMIT = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    int         f;
    int         len;
    logic [7:0] keep;
  } frm_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        udp_enable = 1'b0;
  logic [63:0] s_data [3];
  logic [7:0]  s_keep [3];
  logic        s_valid [3];
  logic        s_last [3];
  logic        arp_tready, icmp_tready, udp_tready;
  logic [2:0]  s_ready;
  logic [63:0] mac_tdata;
  logic [7:0]  mac_tkeep;
  logic        mac_tvalid, mac_tlast;
  logic        mac_tready = 1'b0;
  logic [2:0]  grant;
  logic [15:0] arp_cnt, icmp_cnt, udp_cnt;
  beat_t       mac_b;

  assign s_ready = {udp_tready, icmp_tready, arp_tready};
  assign mac_b   = {mac_tdata, mac_tkeep, mac_tlast};

  int    n_assert = 0;
  int    n_fail = 0;
  beat_t src_q [3][$];
  frm_t  frm_q [3][$];
  beat_t exp_q [$];
  int    fidx [3] = '{0, 0, 0};
  int    exp_cnt [3] = '{0, 0, 0};
  int    acc_beats [3] = '{0, 0, 0};
  logic  acc_now [3] = '{1'b0, 1'b0, 1'b0};
  logic  fire [3] = '{1'b0, 1'b0, 1'b0};
  logic  mid [3] = '{1'b0, 1'b0, 1'b0};
  logic  gaps = 1'b0, rand_ready = 1'b0, fixed_ready = 1'b1;
  logic  hold_pend = 1'b0;
  beat_t hold_b;

  always #5 clk = ~clk;

  eth_tx_arbiter dut (
    .tx_axis_aclk        (clk),
    .tx_axis_areset      (rst),
    .udp_enable          (udp_enable),
    .arp_tx_axis_tdata   (s_data[0]),
    .arp_tx_axis_tkeep   (s_keep[0]),
    .arp_tx_axis_tvalid  (s_valid[0]),
    .arp_tx_axis_tlast   (s_last[0]),
    .arp_tx_axis_tready  (arp_tready),
    .icmp_tx_axis_tdata  (s_data[1]),
    .icmp_tx_axis_tkeep  (s_keep[1]),
    .icmp_tx_axis_tvalid (s_valid[1]),
    .icmp_tx_axis_tlast  (s_last[1]),
    .icmp_tx_axis_tready (icmp_tready),
    .udp_tx_axis_tdata   (s_data[2]),
    .udp_tx_axis_tkeep   (s_keep[2]),
    .udp_tx_axis_tvalid  (s_valid[2]),
    .udp_tx_axis_tlast   (s_last[2]),
    .udp_tx_axis_tready  (udp_tready),
    .mac_tx_axis_tdata   (mac_tdata),
    .mac_tx_axis_tkeep   (mac_tkeep),
    .mac_tx_axis_tvalid  (mac_tvalid),
    .mac_tx_axis_tlast   (mac_tlast),
    .mac_tx_axis_tready  (mac_tready),
    .grant               (grant),
    .arp_frame_cnt       (arp_cnt),
    .icmp_frame_cnt      (icmp_cnt),
    .udp_frame_cnt       (udp_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int s, input int f, input int b, input int len,
                                    input logic [7:0] keep);
    beat_t bt;
    bt.data = {8'(s), 24'(f), 8'(b), 24'(f * 7 + b * 13 + s) ^ 24'h5a5a5a};
    bt.last = (b == len - 1);
    bt.keep = bt.last ? keep : 8'hFF;
    return bt;
  endfunction

  task automatic add_frame(input int s, input int len, input logic [7:0] keep);
    frm_t fr;
    fr.f = fidx[s];
    fr.len = len;
    fr.keep = keep;
    fidx[s]++;
    for (int b = 0; b < len; b++) src_q[s].push_back(mk_beat(s, fr.f, b, len, keep));
    frm_q[s].push_back(fr);
  endtask

  task automatic expect_next(input int s);
    frm_t fr;
    fr = frm_q[s].pop_front();
    for (int b = 0; b < fr.len; b++) exp_q.push_back(mk_beat(s, fr.f, b, fr.len, fr.keep));
    exp_cnt[s]++;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_drain_timeout"}, n < budget, 1'b1);
  endtask

  task automatic check_cnts(input string tag);
    chk({tag, "_arp_cnt"},  arp_cnt,  16'(exp_cnt[0]));
    chk({tag, "_icmp_cnt"}, icmp_cnt, 16'(exp_cnt[1]));
    chk({tag, "_udp_cnt"},  udp_cnt,  16'(exp_cnt[2]));
  endtask

  // Source drivers and MAC-side monitor: sample at negedge, update after posedge.
  initial begin
    beat_t bt;
    for (int s = 0; s < 3; s++) begin
      s_valid[s] = 1'b0; s_data[s] = '0; s_keep[s] = '0; s_last[s] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) fire[s] = 1'b0;
      if (!rst) begin
        if (hold_pend) chk("mac_hold", {mac_tvalid, mac_b}, {1'b1, hold_b});
        hold_pend = mac_tvalid && !mac_tready;
        hold_b = mac_b;
        if (mac_tvalid && mac_tready) begin
          chk("mac_extra_beat", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) chk("mac_beat", mac_b, exp_q.pop_front());
        end
        for (int s = 0; s < 3; s++) begin
          if (s_valid[s] && s_ready[s]) begin
            fire[s] = 1'b1;
            chk("grant_owner", grant, 3'b001 << s);
            chk("other_tready", s_ready & ~(3'b001 << s), 3'b000);
          end
        end
      end
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) begin
        acc_now[s] = 1'b0;
        if (fire[s] && !rst && src_q[s].size() > 0) begin
          bt = src_q[s].pop_front();
          mid[s] = !bt.last;
          acc_beats[s]++;
          acc_now[s] = 1'b1;
        end
        if (src_q[s].size() > 0 && (!mid[s] || !gaps || $urandom_range(0, 3) != 0)) begin
          s_valid[s] = 1'b1;
          {s_data[s], s_keep[s], s_last[s]} = src_q[s][0];
        end else begin
          s_valid[s] = 1'b0; s_data[s] = '0; s_keep[s] = '0; s_last[s] = 1'b0;
        end
      end
      mac_tready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, f, base, starve, pick;
    int rem [3];
    logic udp_w, seen_valid;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outputs", {mac_tvalid, mac_tdata, mac_tkeep, mac_tlast, grant, s_ready}, '0);
    check_cnts("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    // Single 5-beat UDP frame, first output beat one cycle after acceptance
    udp_enable = 1'b1;
    f = fidx[2];
    add_frame(2, 5, 8'h0F);
    expect_next(2);
    n = 0;
    while (!acc_now[2] && n < 50) begin @(negedge clk); #1; n++; end
    chk("t1_accept_timeout", n < 50, 1'b1);
    chk("t1_first_latency", {mac_tvalid, mac_b}, {1'b1, mk_beat(2, f, 0, 5, 8'h0F)});
    wait_drain("t1", 200);
    check_cnts("t1");

    // All three request together: ARP, ICMP, UDP
    add_frame(0, 3, 8'hFF);
    add_frame(1, 2, 8'h07);
    add_frame(2, 4, 8'h01);
    expect_next(0); expect_next(1); expect_next(2);
    wait_drain("t2", 200);
    check_cnts("t2");

    // ARP arrives while ICMP is mid-frame
    base = acc_beats[1];
    add_frame(1, 4, 8'h3F);
    expect_next(1);
    n = 0;
    while (acc_beats[1] < base + 2 && n < 50) begin @(negedge clk); #1; n++; end
    chk("t3_icmp_start_timeout", n < 50, 1'b1);
    add_frame(0, 2, 8'hFF);
    expect_next(0);
    n = 0;
    while (src_q[1].size() > 0 && n < 50) begin
      chk("t3_arp_tready_held", arp_tready, 1'b0);
      @(negedge clk); #1;
      n++;
    end
    wait_drain("t3", 200);
    check_cnts("t3");

    // Starvation guard: UDP forced in after four ARP frames
    for (int i = 0; i < 6; i++) add_frame(0, 2, 8'hFF);
    add_frame(2, 3, 8'h03);
    for (int i = 0; i < 4; i++) expect_next(0);
    expect_next(2);
    expect_next(0); expect_next(0);
    wait_drain("t4", 300);
    check_cnts("t4");

    // UDP blocked while udp_enable is low
    udp_enable = 1'b0;
    add_frame(2, 3, 8'hFF);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      chk("t5_udp_blocked", {grant, udp_tready}, 4'b0000);
    end
    udp_enable = 1'b1;
    expect_next(2);
    @(negedge clk); #1;
    chk("t5_udp_granted", grant, 3'b100);
    wait_drain("t5", 100);
    check_cnts("t5");

    // Randomised traffic with source gaps and 50% MAC backpressure
    gaps = 1'b1;
    rand_ready = 1'b1;
    rem = '{0, 0, 0};
    for (int i = 0; i < 1000; i++) begin
      pick = $urandom_range(0, 2);
      add_frame(pick, $urandom_range(1, 6), 8'hFF >> $urandom_range(0, 7));
      rem[pick]++;
    end
    starve = 0;
    while (rem[0] + rem[1] + rem[2] > 0) begin
      udp_w = rem[2] > 0;
      if (starve == LIMIT && udp_w) pick = 2;
      else if (rem[0] > 0)          pick = 0;
      else if (rem[1] > 0)          pick = 1;
      else                          pick = 2;
      if (pick == 2)  starve = 0;
      else if (udp_w) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      else            starve = 0;
      expect_next(pick);
      rem[pick]--;
    end
    wait_drain("t6", 40000);
    check_cnts("t6");

    // Reset asserted mid-frame with the output stalled
    gaps = 1'b0;
    rand_ready = 1'b0;
    fixed_ready = 1'b0;
    @(negedge clk); #1;
    base = acc_beats[2];
    add_frame(2, 8, 8'hFF);
    n = 0;
    while (acc_beats[2] < base + 2 && n < 50) begin @(negedge clk); #1; n++; end
    chk("t7_fill_timeout", n < 50, 1'b1);
    rst = 1'b1;
    #1;
    chk("t7_rst_outputs", {mac_tvalid, mac_tdata, mac_tkeep, mac_tlast, grant, s_ready}, '0);
    chk("t7_rst_counters", {arp_cnt, icmp_cnt, udp_cnt}, 48'h0);
    for (int s = 0; s < 3; s++) begin
      src_q[s].delete(); frm_q[s].delete(); exp_cnt[s] = 0; mid[s] = 1'b0;
    end
    exp_q.delete();
    hold_pend = 1'b0;
    fixed_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      seen_valid = seen_valid | mac_tvalid;
    end
    chk("t7_no_stale_beat", seen_valid, 1'b0);
    add_frame(2, 2, 8'h0F);
    expect_next(2);
    wait_drain("t7", 100);
    check_cnts("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
